multiplier_32_bit: RTL and testbench

MULTIPLIER_32_BIT -- requirements
Module: multiplier_32_bit

---
 rtl/multiplier_32_bit_if.sv | 26 ++
 rtl/multiplier_32_bit.sv | 112 +++++++++++
 tb/tb_multiplier_32_bit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/multiplier_32_bit_if.sv
// Request/response bundle for the 32x32 sequential multiplier.
// The master drives the operands and the start level; the slave (the
// multiplier) returns the registered product and its valid flag.
interface multiplier_32_bit_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] result;
  logic        done;

  modport master (
    output start,
    output A,
    output B,
    input  result,
    input  done
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output result,
    output done
  );
endinterface

// File: rtl/multiplier_32_bit.sv
// Sequential shift-and-add unsigned multiplier, 32x32 -> 64 bits.
// An operation is accepted on a rising edge of the start level (IDLE or
// DONE only), processes one multiplier bit per clock, and holds the
// product with done=1 until the next accepted start or reset.
// Optional feature: define MULT_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero instead of always taking 32 cycles.
module multiplier_32_bit (
  input logic                clk,
  input logic                rst,
  multiplier_32_bit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        start_q;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] accum_q, accum_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] result_q, result_d;
  logic        done_q, done_d;

  logic        startEvent;
  logic [63:0] accumSum;
  logic [31:0] mplierShift;
  logic        lastStep;

  // A start only counts on its 0->1 transition, so a held level never restarts.
  assign startEvent  = bus.start & ~start_q;

  // The accumulator is 64 bits wide and the true product fits, so this never wraps.
  assign accumSum    = accum_q + (mplier_q[0] ? mcand_q : 64'd0);
  assign mplierShift = mplier_q >> 1;

`ifdef MULT_EARLY_EXIT_EN
  // Stop once no set bits remain to be processed, bounded by the 32nd step.
  assign lastStep = (mplierShift == 32'd0) || (count_q == 6'd31);
`else
  // Fixed-latency build: always walk all 32 multiplier bits.
  assign lastStep = (count_q == 6'd31);
`endif

  // Next-state and datapath control; every register holds unless told otherwise.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    accum_d  = accum_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (startEvent) begin
          mcand_d  = {32'd0, bus.A};
          mplier_d = bus.B;
          accum_d  = 64'd0;
          count_d  = 6'd0;
          done_d   = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        accum_d  = accumSum;
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = mplierShift;
        count_d  = count_q + 6'd1;
        if (lastStep) begin
          result_d = accumSum;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state clears asynchronously on reset, aborting any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      accum_q  <= 64'd0;
      count_q  <= 6'd0;
      result_q <= 64'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.start;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      accum_q  <= accum_d;
      count_q  <= count_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_multiplier_32_bit.sv
// Self-checking bench for multiplier_32_bit: directed operand vectors with
// hand-computed products, start sequencing, async reset behaviour and a
// random sweep against a 64-bit reference product. Expected latency follows
// MULT_EARLY_EXIT_EN when the bench is built with that macro.
module tb_multiplier_32_bit;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic [63:0] lastResult;

  multiplier_32_bit_if bus ();

  multiplier_32_bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  function automatic int expLatency(input logic [31:0] b);
`ifdef MULT_EARLY_EXIT_EN
    int lat;
    lat = 1;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) lat = i + 1;
    end
    return lat;
`else
    return 32;
`endif
  endfunction

  // Starts counting at the accepting edge; checks done drops, result holds,
  // then measures latency and checks the product. Scrambles operands mid-run.
  task automatic waitDone(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expProd, input string tag);
    int lat;
    lat = 0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_doneLowAtAccept"}, {63'd0, bus.done}, 64'd0);
    checkOutput({tag, "_resultHeldAtAccept"}, bus.result, lastResult);
    bus.A = ~a;
    bus.B = ~b;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expLatency(b)));
    checkOutput({tag, "_product"}, bus.result, expProd);
    lastResult = expProd;
  endtask

  // Ensures one sampled low on start, then raises it with fresh operands.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expProd, input string tag);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    waitDone(a, b, expProd, tag);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    compared   = 0;
    mismatched = 0;
    lastResult = 64'd0;
    bus.start  = 1'b0;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    rst        = 1'b1;

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b0;
    #1;
    checkOutput("resetResult", bus.result, 64'd0);
    checkOutput("resetDone", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Small product, then done/result must hold while start stays high.
    applyStimulus(32'd3, 32'd5, 64'h0000_0000_0000_000F, "threeTimesFive");
    repeat (5) @(posedge clk);
    #1;
    checkOutput("holdDone", {63'd0, bus.done}, 64'd1);
    checkOutput("holdResult", bus.result, 64'h0000_0000_0000_000F);

    // Largest operands.
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "maxOperands");

    // New operands with start still high must not restart.
    @(negedge clk);
    bus.A = 32'd7;
    bus.B = 32'd9;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("noRestartDone", {63'd0, bus.done}, 64'd1);
    checkOutput("noRestartResult", bus.result, 64'hFFFF_FFFE_0000_0001);

    // Drop start for one cycle, raise it again: a genuine new operation.
    applyStimulus(32'd7, 32'd9, 64'h0000_0000_0000_003F, "sevenTimesNine");

    // Reset 10 cycles into an operation aborts it immediately.
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.A     = 32'h1234_5678;
    bus.B     = 32'h9ABC_DEF0;
    bus.start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midResetResult", bus.result, 64'd0);
    checkOutput("midResetDone", {63'd0, bus.done}, 64'd0);
    lastResult = 64'd0;
    bus.start  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("postResetIdleDone", {63'd0, bus.done}, 64'd0);
    checkOutput("postResetIdleResult", bus.result, 64'd0);

    // A start level already high at reset release is accepted on the first edge.
    @(negedge clk);
    rst       = 1'b0;
    bus.A     = 32'd6;
    bus.B     = 32'd7;
    bus.start = 1'b1;
    lastResult = 64'd0;
    @(negedge clk);
    rst = 1'b1;
    waitDone(32'd6, 32'd7, 64'h0000_0000_0000_002A, "startHeldThroughReset");

    // Early-exit boundary operands (latency expectation depends on the build).
    applyStimulus(32'hDEAD_BEEF, 32'd0, 64'd0, "zeroMultiplier");
    applyStimulus(32'd2, 32'h8000_0000, 64'h0000_0001_0000_0000, "topBitMultiplier");
    applyStimulus(32'h0001_0000, 32'h0000_0001, 64'h0000_0000_0001_0000, "unitMultiplier");

    // Random sweep against the 64-bit reference product.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = rb >> $urandom_range(0, 31);
      applyStimulus(ra, rb, {32'd0, ra} * {32'd0, rb}, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
